// File: rtl/rgb565_decimate_2x2.sv
// 2x2 box-average decimator for the RGB565 capture stream, one line buffer of partial sums.
// Define DECIMATE_ROUND_EN to round half up instead of truncating the averages.
module rgb565_decimate_2x2 #(
   parameter int SRC_W = 640,
   parameter int SRC_H = 480
) (
   input  logic        p_clock,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic        in_frame_done,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic [16:0] out_addr,
   output logic        out_frame_done,
   output logic        out_frame_err
);
   localparam int HW = SRC_W / 2;
   localparam int XW = $clog2(SRC_W);
   localparam int YW = $clog2(SRC_H);
   localparam logic [18:0] FULL_CNT = 19'(SRC_W * SRC_H);
`ifdef DECIMATE_ROUND_EN
   localparam logic [1:0] RND = 2'd2;
`else
   localparam logic [1:0] RND = 2'd0;
`endif

   typedef enum logic {SYNC, ACTIVE} state_t;
   state_t state, state_nxt;
   logic acc, fd_act, proc;

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [XW-2:0] idx;
   logic          full;
   logic [18:0]   cnt, cnt_inc;
   logic [15:0]   hold;

   logic [5:0]  h_r, h_b;
   logic [6:0]  h_g;
   logic [16:0] addr_c;
   logic [18:0] lbuf [HW];
   logic [18:0] lb_q;

   logic        s1_v;
   logic [18:0] s1_sum;
   logic [16:0] s1_addr;
   logic        s2_v;
   logic [6:0]  s2_r, s2_b;
   logic [7:0]  s2_g;
   logic [16:0] s2_addr;
   logic [6:0]  q_r, q_b;
   logic [7:0]  q_g;
   logic [15:0] pix_c;
   logic [2:0]  fd_p, err_p;

   always_ff @(posedge p_clock) begin
      if (!rst_n) state <= SYNC;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      acc       = 1'b0;
      fd_act    = 1'b0;
      unique case (state)
         SYNC: begin
            if (in_frame_done) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            acc    = in_valid;
            fd_act = in_frame_done;
         end
         default: state_nxt = SYNC;
      endcase
   end

   assign proc    = acc & ~full;
   assign idx     = x[XW-1:1];
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 19'(acc);
   assign h_r     = {1'b0, hold[15:11]} + {1'b0, in_data[15:11]};
   assign h_g     = {1'b0, hold[10:5]} + {1'b0, in_data[10:5]};
   assign h_b     = {1'b0, hold[4:0]} + {1'b0, in_data[4:0]};
   assign addr_c  = 17'(32'(y >> 1) * HW + 32'(idx));

   // Same-edge pixel is processed by the pipeline; the clear wins here.
   always_ff @(posedge p_clock) begin
      if (!rst_n || state == SYNC || fd_act) begin
         x    <= '0;
         y    <= '0;
         full <= 1'b0;
         cnt  <= '0;
         hold <= '0;
      end else if (acc) begin
         cnt <= cnt_inc;
         if (!full) begin
            if (!x[0]) hold <= in_data;
            if (x == XW'(SRC_W - 1)) begin
               x <= '0;
               if (y == YW'(SRC_H - 1)) full <= 1'b1;
               else                     y    <= y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end
      end
   end

   // Contents are never reset: even rows always refill before odd rows read.
   always_ff @(posedge p_clock) begin
      if (proc && x[0] && !y[0]) lbuf[idx] <= {h_r, h_g, h_b};
      if (proc && x[0])          lb_q      <= lbuf[idx];
   end

   assign q_r   = s2_r + 7'(RND);
   assign q_g   = s2_g + 8'(RND);
   assign q_b   = s2_b + 7'(RND);
   assign pix_c = {5'(q_r >> 2), 6'(q_g >> 2), 5'(q_b >> 2)};

   always_ff @(posedge p_clock) begin
      if (!rst_n) begin
         s1_v           <= 1'b0;
         s1_sum         <= '0;
         s1_addr        <= '0;
         s2_v           <= 1'b0;
         s2_r           <= '0;
         s2_g           <= '0;
         s2_b           <= '0;
         s2_addr        <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_addr       <= '0;
         fd_p           <= '0;
         err_p          <= '0;
         out_frame_done <= 1'b0;
         out_frame_err  <= 1'b0;
      end else begin
         s1_v <= proc & x[0] & y[0];
         if (proc && x[0]) begin
            s1_sum  <= {h_r, h_g, h_b};
            s1_addr <= addr_c;
         end
         s2_v <= s1_v;
         if (s1_v) begin
            s2_r    <= {1'b0, s1_sum[18:13]} + {1'b0, lb_q[18:13]};
            s2_g    <= {1'b0, s1_sum[12:6]} + {1'b0, lb_q[12:6]};
            s2_b    <= {1'b0, s1_sum[5:0]} + {1'b0, lb_q[5:0]};
            s2_addr <= s1_addr;
         end
         out_valid <= s2_v;
         if (s2_v) begin
            out_data <= pix_c;
            out_addr <= s2_addr;
         end
         fd_p           <= {fd_p[1:0], fd_act};
         err_p          <= {err_p[1:0], fd_act & (cnt_inc != FULL_CNT)};
         out_frame_done <= fd_p[2];
         out_frame_err  <= fd_p[2] & err_p[2];
      end
   end

endmodule

// File: doc/rgb565_decimate_2x2.md
# rgb565_decimate_2x2

Downstream stage of the OV7670 capture path. Consumes the RGB565 pixel stream and end-of-frame pulse produced by the camera capture block, averages each 2x2 source block into one pixel, and emits a 320x240 stream with linear write addresses for the display framebuffer. It holds one line buffer of partial sums and reports malformed frames.

## Interface
Parameters:
- `SRC_W`, 640: source pixels per row; must be even.
- `SRC_H`, 480: source rows per frame; must be even.

Ports:
- `p_clock`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low. One clock (`p_clock`); reset is synchronous and active-low.
- `in_valid`  in  1  `in_data` is sampled on the rising edge where this is high.
- `in_data`  in  16  RGB565 source pixel, R[15:11] G[10:5] B[4:0].
- `in_frame_done`  in  1  one-cycle end-of-frame pulse from capture.
- `out_valid`  out  1  one-cycle pulse; `out_data` and `out_addr` are valid.
- `out_data`  out  16  averaged RGB565 pixel.
- `out_addr`  out  17  (y/2)*(SRC_W/2) + x/2; range 0..76799 at default size.
- `out_frame_done`  out  1  one-cycle pulse after the last output of a frame.
- `out_frame_err`  out  1  valid only with `out_frame_done`; high if accepted pixel count ≠ SRC_W*SRC_H.

## Operation
- States: SYNC and ACTIVE. Reset enters SYNC. In SYNC all input pixels are discarded. `in_frame_done` moves to ACTIVE with counters cleared and emits no `out_frame_done`.
- ACTIVE uses internal counters x (0..SRC_W-1) and y (0..SRC_H-1), not the capture address.
  - Each accepted pixel increments x.
  - At x = SRC_W-1, x wraps to 0 and y increments.
  - When y would pass SRC_H-1, it saturates and pixels are dropped, but they are still counted.
- Pixel count is a 19-bit saturating counter of all `in_valid` samples in ACTIVE.
- Even x: hold the pixel's R/G/B in a register.
- Odd x: form the horizontal sums: R 6b, G 7b, B 6b.
  - Even y: write the sums to line buffer entry x/2 (SRC_W/2 entries × 19b, synchronous read).
  - Odd y: read entry x/2 and add the sums, giving R 7b, G 8b, B 7b. Each channel result is sum>>2 (see Configuration). Emit it at address (y>>1)*(SRC_W/2)+(x>>1).
- `in_frame_done` in ACTIVE:
  - Clears x, y, the held pixel and the pixel count for the next frame.
  - Pulses `out_frame_done` after the pipeline drains.
  - Sets `out_frame_err` = (count ≠ SRC_W*SRC_H).
- `in_valid` and `in_frame_done` on the same edge: the pixel belongs to the ending frame and is counted and processed before the clear.
- A partial final row or an odd trailing pixel produces no output.
- Line buffer contents are not reset; even rows always overwrite them before use.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_addr` = 0.
  - `out_frame_done` = 0, `out_frame_err` = 0.
  - State SYNC; all counters 0.
- Reset mid-frame: in-flight pipeline entries are discarded and no `out_valid` follows. The block returns to SYNC.
- Latency: odd-x/odd-y pixel sampled at edge T, then `out_valid` is high in the cycle after edge T+2.
- Throughput: one pixel per cycle is sustained. The capture source delivers at most one every two cycles.
- `in_frame_done` at edge T gives `out_frame_done` high in the cycle after edge T+3. This is always after the final `out_valid` of that frame.
- `out_data` and `out_addr` hold their values between pulses.

## Configuration
- `DECIMATE_ROUND_EN` defined: +2 is added to each channel's 4-pixel sum before >>2 (round half up). The result cannot overflow: max R is 124+2 → 31.
- Not defined: plain truncation, sum>>2.

## Test plan
- Reset, then `in_frame_done`, then 307200 pixels of 0xFFFF, then `in_frame_done` → 76800 `out_valid` pulses with data 0xFFFF and addresses 0..76799 in order. `out_frame_done` has `out_frame_err`=0.
- Block (0,0) with R values 1,1,0,0 (G=B=0), rest 0x0000 → address 0 gives data 0x0000 when truncating. With `DECIMATE_ROUND_EN` it gives 0x0800.
- Pixels sent before the first `in_frame_done` after reset → no `out_valid`, no `out_frame_done`.
- Frame of 307199 pixels then `in_frame_done` → 76799 outputs; `out_frame_done` with `out_frame_err`=1, 3 cycles after the pulse edge.
- Frame of 307201 pixels → extra pixel dropped, 76800 outputs, `out_frame_err`=1. Next frame clean → `out_frame_err`=0.
- `rst_n` low for one cycle mid row 1 → no further `out_valid`. All outputs 0; pixels are ignored until the next `in_frame_done`.
